spi_xfer_ctrl: RTL

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_byte_fifo.sv | 49 ++++
 rtl/spi_xfer_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, defaults and helpers for the SPI transfer controller
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STORE = 2'd3
    } spi_state_t;

    localparam int DEFAULT_DEPTH   = 8;
    localparam int DEFAULT_TIMEOUT = 1024;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_byte_fifo.sv
// rtl/spi_byte_fifo.sv - byte FIFO with zero-latency head and occupancy level
module spi_byte_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head_data,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] level
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_cnt;
    logic [AW:0] rd_cnt;
    logic        do_push;
    logic        do_pop;

    // Counters carry one extra bit so full and empty stay distinguishable after wrap.
    assign level     = wr_cnt - rd_cnt;
    assign full      = (level == FULL_LVL);
    assign empty     = (level == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = empty ? 8'h00 : mem[rd_cnt[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_cnt[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (do_push) wr_cnt <= wr_cnt + ONE;
            if (do_pop)  rd_cnt <= rd_cnt + ONE;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - queues bytes to an SPI master one transfer at a time with a watchdog
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    output logic [7:0]            m_datain,
    output logic                  m_start,
    output logic                  m_cpol,
    output logic                  m_cpha,
    input  logic                  m_finish,
    input  logic [7:0]            m_dataout,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [clog2(DEPTH):0] tx_level,
    output logic [clog2(DEPTH):0] rx_level
);
    localparam int WW = clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WDOG_ONE = {{(WW-1){1'b0}}, 1'b1};

    spi_state_t    state;
    spi_state_t    state_nxt;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_full;
    logic          rx_empty;
    logic          tx_pop;
    logic          rx_push;
    logic [7:0]    tx_head;
    logic [7:0]    rx_byte;
    logic [WW-1:0] wdog;
    logic          wdog_expired;

    spi_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head_data (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    spi_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_byte),
        .pop       (rx_ready),
        .head_data (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    assign tx_ready     = !tx_full;
    assign rx_valid     = !rx_empty;
    assign busy         = (state != ST_IDLE);
    // Expires on the last allowed WAIT cycle; a finish in that same cycle still wins.
    assign wdog_expired = (state == ST_WAIT) && (int'(wdog) == TIMEOUT - 1);

    always_comb begin
        state_nxt = state;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        m_start   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!tx_empty && !rx_full) begin
                    state_nxt = ST_ISSUE;
                    tx_pop    = 1'b1;
                end
            end
            ST_ISSUE: begin
                m_start   = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (m_finish)          state_nxt = ST_STORE;
                else if (wdog_expired) state_nxt = ST_IDLE;
            end
            ST_STORE: begin
                rx_push   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            m_datain    <= 8'h00;
            m_cpol      <= 1'b0;
            m_cpha      <= 1'b0;
            rx_byte     <= 8'h00;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (tx_pop) begin
                m_datain <= tx_head;
                m_cpol   <= cfg_cpol;
                m_cpha   <= cfg_cpha;
            end
            if (state == ST_WAIT && m_finish) rx_byte <= m_dataout;
            wdog <= (state == ST_WAIT) ? wdog + WDOG_ONE : '0;
            if (wdog_expired && !m_finish) timeout_err <= 1'b1;
        end
    end

endmodule
